// File: rtl/write_back_arbiter.sv
// write_back_arbiter: retires results from NUM_PORTS functional units through one register-file write port.
// Latency: handshake at edge T -> entry FULL in T+1 -> write_back_output pulse in T+2; one write-back per cycle.
// Backpressure: unit_ready_output[i] = slot i EMPTY or granted this cycle; never depends on unit_valid_input.
// Build option WRITE_BACK_ROUND_ROBIN_EN: defined -> round-robin grant; undefined -> fixed priority, lowest index wins.

package register_file_params;
  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;
  localparam int OPERAND_WIDTH             = 32;
endpackage

module write_back_arbiter
  import register_file_params::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [NUM_PORTS-1:0]                                unit_valid_input,
  output logic [NUM_PORTS-1:0]                                unit_ready_output,
  input  logic [NUM_PORTS-1:0][REGISTER_DESCRIPTOR_WIDTH-1:0] unit_register_input,
  input  logic [NUM_PORTS-1:0][OPERAND_WIDTH-1:0]             unit_result_input,
  output logic                                                write_back_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0]                write_back_register_output,
  output logic [OPERAND_WIDTH-1:0]                            result_output,
  output logic                                                pending_output
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // Per-slot holding state: bit i set means slot i is FULL.
  logic [NUM_PORTS-1:0] r_full;
  logic [NUM_PORTS-1:0] w_full_next;
  logic [NUM_PORTS-1:0] w_xfer;
  logic [NUM_PORTS-1:0] w_keep;
  logic [NUM_PORTS-1:0] w_grant_oh;
  logic                 w_grant_vld;
  logic [IDX_W-1:0]     w_grant_idx;

  logic [NUM_PORTS-1:0][REGISTER_DESCRIPTOR_WIDTH-1:0] r_hold_reg;
  logic [NUM_PORTS-1:0][OPERAND_WIDTH-1:0]             r_hold_dat;

  logic                                 r_wb_vld;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] r_wb_reg;
  logic [OPERAND_WIDTH-1:0]             r_wb_dat;

`ifdef WRITE_BACK_ROUND_ROBIN_EN
  // One extra bit so last_grant + offset never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;
  logic [IDX_W-1:0] r_last_grant;

  // Round-robin pick: scan from last_grant+1 upward, wrapping modulo NUM_PORTS.
  always_comb begin
    logic [SUM_W-1:0] w_sum;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_sum = {1'b0, r_last_grant} + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_PORTS)) begin
        w_sum = w_sum - SUM_W'(NUM_PORTS);
      end
      if (!w_grant_vld && r_full[w_sum[IDX_W-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_sum[IDX_W-1:0];
      end
    end
    w_grant_oh = w_grant_vld ? (NUM_PORTS'(1) << w_grant_idx) : '0;
  end

  // Remember the last winner so the next search starts just past it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
    end else if (w_grant_vld) begin
      r_last_grant <= w_grant_idx;
    end
  end
`else
  // Fixed-priority pick: descending scan so the lowest FULL index is written last and wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (r_full[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IDX_W'(i);
      end
    end
    w_grant_oh = w_grant_vld ? (NUM_PORTS'(1) << w_grant_idx) : '0;
  end
`endif

  // Handshake outputs: ready from slot state and grant only; register-0 transfers are accepted but not kept.
  always_comb begin
    unit_ready_output = ~r_full | w_grant_oh;
    w_xfer            = unit_valid_input & unit_ready_output;
    w_keep            = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_keep[i] = w_xfer[i] && (unit_register_input[i] != '0);
    end
    pending_output = |r_full;
  end

  // Next slot state: a grant empties the slot, a kept transfer (re)fills it in the same cycle.
  always_comb begin
    w_full_next = r_full & ~w_grant_oh;
    w_full_next = (w_full_next & ~w_xfer) | w_keep;
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_full <= '0;
    end else begin
      r_full <= w_full_next;
    end
  end

  // Capture destination and data into the slot on a kept transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_reg <= '0;
      r_hold_dat <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_keep[i]) begin
          r_hold_reg[i] <= unit_register_input[i];
          r_hold_dat[i] <= unit_result_input[i];
        end
      end
    end
  end

  // Write-back port: one-cycle enable per grant; data holds its last value between grants.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_vld <= 1'b0;
      r_wb_reg <= '0;
      r_wb_dat <= '0;
    end else begin
      r_wb_vld <= w_grant_vld;
      if (w_grant_vld) begin
        r_wb_reg <= r_hold_reg[w_grant_idx];
        r_wb_dat <= r_hold_dat[w_grant_idx];
      end
    end
  end

  assign write_back_output          = r_wb_vld;
  assign write_back_register_output = r_wb_reg;
  assign result_output              = r_wb_dat;

endmodule

// File: tb/tb_write_back_arbiter.sv
module tb_write_back_arbiter;

  localparam int N  = 4;
  localparam int RW = register_file_params::REGISTER_DESCRIPTOR_WIDTH;
  localparam int OW = register_file_params::OPERAND_WIDTH;

  typedef struct packed {
    logic [RW-1:0] r;
    logic [OW-1:0] d;
  } req_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         vld;
  logic [N-1:0]         rdy;
  logic [N-1:0][RW-1:0] ureg;
  logic [N-1:0][OW-1:0] udat;
  logic                 wb;
  logic [RW-1:0]        wb_reg;
  logic [OW-1:0]        wb_dat;
  logic                 pend;

  write_back_arbiter #(.NUM_PORTS(N)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .unit_valid_input           (vld),
    .unit_ready_output          (rdy),
    .unit_register_input        (ureg),
    .unit_result_input          (udat),
    .write_back_output          (wb),
    .write_back_register_output (wb_reg),
    .result_output              (wb_dat),
    .pending_output             (pend)
  );

  always #5 clk = ~clk;

  // Behavioural model: which slots hold a result, and what the write-back port shows.
  bit            m_full [N];
  logic [RW-1:0] m_reg  [N];
  logic [OW-1:0] m_dat  [N];
  int            m_last;
  bit            m_wb;
  logic [RW-1:0] m_wb_reg;
  logic [OW-1:0] m_wb_dat;
  bit            m_xfer [N];

  req_t          q [N][$];
  logic [RW-1:0] wb_log [$];
  int            n_total;
  int            n_pass;
  int            gap_pct;
  int            pos;
  logic [RW-1:0] rnd_reg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Index of the slot that must be granted now, -1 if all slots are empty.
  function automatic int m_pick();
    int p;
    for (int k = 1; k <= N; k++) begin
`ifdef WRITE_BACK_ROUND_ROBIN_EN
      p = (m_last + k) % N;
`else
      p = k - 1;
`endif
      if (m_full[p]) return p;
    end
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_reg[i]  = '0;
      m_dat[i]  = '0;
      m_xfer[i] = 1'b0;
    end
    m_last   = N - 1;
    m_wb     = 1'b0;
    m_wb_reg = '0;
    m_wb_dat = '0;
  endtask

  task automatic compare();
    logic [N-1:0] er;
    int           g;
    bit           anyf;
    g    = m_pick();
    anyf = 1'b0;
    for (int i = 0; i < N; i++) begin
      anyf  = anyf | m_full[i];
      er[i] = !m_full[i] || (g == i);
    end
    chk("write_back", wb, m_wb);
    chk("wb_register", wb_reg, m_wb_reg);
    chk("result", wb_dat, m_wb_dat);
    chk("pending", pend, anyf);
    chk("ready", rdy, er);
    if (wb === 1'b1) wb_log.push_back(wb_reg);
  endtask

  // Advance model and DUT by one edge using the inputs currently driven, then compare.
  task automatic tick();
    int g;
    g = m_pick();
    for (int i = 0; i < N; i++) m_xfer[i] = rst && vld[i] && (!m_full[i] || g == i);
    if (!rst) begin
      m_reset();
    end else begin
      if (g >= 0) begin
        m_wb      = 1'b1;
        m_wb_reg  = m_reg[g];
        m_wb_dat  = m_dat[g];
        m_full[g] = 1'b0;
        m_last    = g;
      end else begin
        m_wb = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_xfer[i] && ureg[i] != '0) begin
          m_full[i] = 1'b1;
          m_reg[i]  = ureg[i];
          m_dat[i]  = udat[i];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  // Unit-side protocol: hold valid and data until transferred, then present the next queued item.
  task automatic drive();
    req_t t;
    for (int i = 0; i < N; i++) begin
      if (m_xfer[i]) vld[i] = 1'b0;
      if (!vld[i]) begin
        ureg[i] = RW'($urandom);
        udat[i] = $urandom;
        if (q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
          t       = q[i].pop_front();
          vld[i]  = 1'b1;
          ureg[i] = t.r;
          udat[i] = t.d;
        end
      end
    end
  endtask

  task automatic push(input int p, input logic [RW-1:0] r, input logic [OW-1:0] d);
    req_t t;
    t.r = r;
    t.d = d;
    q[p].push_back(t);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      vld[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    flush();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    gap_pct = 0;
    rst     = 1'b0;
    vld     = '0;
    ureg    = '0;
    udat    = '0;
    m_reset();
    @(negedge clk);
    tick();
    tick();
    chk("rst_write_back", wb, 0);
    chk("rst_register", wb_reg, 0);
    chk("rst_result", wb_dat, 0);
    chk("rst_pending", pend, 0);
    chk("rst_ready", rdy, 4'hF);
    rst = 1'b1;
    tick();

    // Single port: result retired two cycles after the handshake edge.
    push(2, 5, 32'hDEADBEEF);
    drive(); tick();
    chk("sp_pending_t1", pend, 1);
    chk("sp_wb_t1", wb, 0);
    drive(); tick();
    chk("sp_wb_t2", wb, 1);
    chk("sp_reg_t2", wb_reg, 5);
    chk("sp_data_t2", wb_dat, 32'hDEADBEEF);
    chk("sp_pending_t2", pend, 0);
    drive(); tick();
    chk("sp_wb_t3", wb, 0);
    chk("sp_hold_t3", wb_dat, 32'hDEADBEEF);

    // Register 0 is accepted and dropped.
    push(0, 0, 32'h1234);
    drive();
    chk("r0_ready", rdy[0], 1);
    for (int c = 0; c < 5; c++) begin
      tick(); drive();
      chk("r0_wb", wb, 0);
      chk("r0_pending", pend, 0);
    end

    // Contention: all four ports on the same edge, retired in port order.
    do_reset();
    for (int i = 0; i < N; i++) push(i, RW'(i + 1), OW'((i + 1) * 32'h11111111));
    drive(); tick();
    chk("ct_ready_first", rdy, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      drive(); tick();
      chk("ct_wb", wb, 1);
      chk("ct_reg", wb_reg, k);
      chk("ct_result", wb_dat, k * 32'h11111111);
      if (k < 4) chk("ct_ready", rdy, (1 << (k + 1)) - 1);
    end

    // Back-to-back from a single port.
    tick();
    for (int k = 0; k < 3; k++) push(1, RW'(6 + k), $urandom);
    drive();
    chk("bb_ready_first", rdy[1], 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive();
      chk("bb_ready", rdy[1], 1);
      tick();
      chk("bb_wb", wb, 1);
      chk("bb_reg", wb_reg, 6 + k);
    end

    // Busy port 0 against port 3: order depends on the arbitration build.
    do_reset();
    wb_log.delete();
    for (int k = 0; k < 6; k++) push(0, 9, k);
    push(3, 10, 32'hA5A5A5A5);
    for (int c = 0; c < 12; c++) begin
      drive(); tick();
    end
    pos = -1;
    foreach (wb_log[j]) if (pos < 0 && wb_log[j] == 10) pos = j;
`ifdef WRITE_BACK_ROUND_ROBIN_EN
    chk("prio_port3_position", pos, 1);
`else
    chk("prio_port3_position", pos, 6);
`endif
    chk("prio_count", wb_log.size(), 7);

    // Reset with three entries pending drops them all.
    do_reset();
    for (int i = 1; i < N; i++) push(i, RW'(10 + i), $urandom);
    drive(); tick();
    chk("mr_pending_before", pend, 1);
    flush();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_wb", wb, 0);
    chk("mr_pending", pend, 0);
    chk("mr_ready", rdy, 4'hF);
    wb_log.delete();
    for (int c = 0; c < 5; c++) begin
      drive(); tick();
    end
    chk("mr_no_wb", wb_log.size(), 0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      gap_pct = (c < 1000) ? 30 : 0;
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 2 && $urandom_range(99) < 45) begin
          rnd_reg = RW'($urandom);
          if ($urandom_range(7) == 0) rnd_reg = '0;
          push(i, rnd_reg, $urandom);
        end
      end
      if ($urandom_range(249) == 0) do_reset();
      else begin
        drive(); tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/write_back_arbiter.md
# write_back_arbiter

Collects results from up to `NUM_PORTS` functional units over valid/ready channels and serialises them into the single write-back port of `global_register` (`write_back_input`, `write_back_register_input`, `result_input`). It sits between the execute stage and the register file and retires at most one result per cycle, so that reservations made at issue are cleared in a bounded, fair order. Each unit gets a one-entry holding register, so a producer can hand off a result and continue without waiting for arbitration.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of functional-unit result channels (≥2).
- `REGISTER_DESCRIPTOR_WIDTH`, `OPERAND_WIDTH`: taken from `register_file_params`; not overridable here.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low (state clears on a rising edge where `rst`=0).
- `unit_valid_input` input `[NUM_PORTS]`: unit i presents a result.
- `unit_ready_output` output `[NUM_PORTS]`: holding register i can accept this cycle.
- `unit_register_input` input `[NUM_PORTS][REGISTER_DESCRIPTOR_WIDTH]`: destination register for unit i.
- `unit_result_input` input `[NUM_PORTS][OPERAND_WIDTH]`: result data for unit i.
- `write_back_output` output 1: one-cycle write-enable pulse to the register file.
- `write_back_register_output` output `REGISTER_DESCRIPTOR_WIDTH`: destination of the current write-back.
- `result_output` output `OPERAND_WIDTH`: data of the current write-back.
- `pending_output` output 1: at least one holding register is occupied.

## Operation
- Handshake per port: transfer occurs on an edge where `unit_valid_input[i]` and `unit_ready_output[i]` are both 1. Valid must not depend on ready; once valid is asserted, the unit keeps data stable until the transfer.
- Holding register i state: EMPTY or FULL. EMPTY→FULL on a transfer. FULL→EMPTY when granted. FULL→FULL on a same-cycle grant plus new transfer.
- `unit_ready_output[i]` = EMPTY(i) OR grant(i) this cycle. This is combinational from state and grant only, never from `unit_valid_input`.
- Register 0 is hard-wired: a transfer with `unit_register_input[i]`=0 is accepted (ready behaves normally) and discarded. It never fills the holding register and never produces `write_back_output`.
- Arbitration: each cycle, among FULL holding registers, exactly one is granted if any is FULL. The grant loads the output registers: `write_back_output`=1, register and result from the granted entry. With no FULL entry, `write_back_output`=0 and the data outputs hold their last values.
- Round-robin pointer `last_grant` updates to the granted index on every grant. Search starts at `last_grant+1` and wraps modulo `NUM_PORTS`.
- `pending_output` = OR of all FULL flags.
- The arbiter does not deduplicate. Two entries with the same destination are written in grant order, and the later write wins in the register file.

## Timing
- Reset values: all holding registers EMPTY; `write_back_output`=0; `write_back_register_output`=0; `result_output`=0; `pending_output`=0; `last_grant`=`NUM_PORTS-1` (port 0 has first priority); `unit_ready_output`=all 1 in the first cycle after reset.
- Latency: handshake at edge T → entry FULL in cycle T+1 → granted in T+1 → `write_back_output`=1 in cycle T+2 → register file updated at end of T+2.
- Throughput: one write-back per cycle. A single active port sustains one transfer per cycle.
- Worst-case wait (round robin) for a FULL entry: `NUM_PORTS` cycles.
- Reset mid-operation: all pending entries are dropped, and outputs take their reset values in the cycle after the reset edge. The scoreboard owner must reset the register file in the same cycle.

## Configuration
- `WRITE_BACK_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, where the lowest FULL index always wins and `last_grant` is not implemented. A continuously busy low-index port may starve higher ports.
  - Handshake and latency are identical in both builds.

## Test plan
- Single port: unit 2 sends reg 5 / 0xDEADBEEF at edge 10 → `write_back_output`=1, reg 5, 0xDEADBEEF in cycle 12 only; `pending_output`=1 in cycle 11 only.
- Register 0 drop: unit 0 sends reg 0 / 0x1234 → `unit_ready_output[0]`=1; `write_back_output` and `pending_output` stay 0 for 5 cycles.
- Contention (round robin): all 4 ports send regs 1–4 on the same edge → write-backs in order reg 1, 2, 3, 4 on four consecutive cycles. Ports 1–3 see ready=0 until granted.
- Back-to-back: unit 1 valid every cycle with regs 6, 7, 8, no other traffic → ready stays 1 and write-backs of 6, 7, 8 appear on consecutive cycles.
- Fixed priority (macro undefined): port 0 continuously valid, port 3 valid → port 3 is never granted while port 0 is valid; it is granted the cycle after port 0 drops.
- Reset mid-operation: 3 entries FULL, `rst`=0 for one edge → next cycle `write_back_output`=0, `pending_output`=0, all ready=1, and no further write-backs occur.
